// File: rtl/quadrature_decoder.sv
// quadrature_decoder: A/B/I encoder inputs are synchronised, debounced and
// decoded into a signed 32-bit position with direction, illegal-transition
// and index flags. Windowed velocity measurement is built only when the
// QUADRATURE_DECODER_VELOCITY_EN macro is defined; otherwise velocity and
// vel_valid are tied to zero.
module quadrature_decoder #(
  parameter int FILTER_LEN = 3,
  parameter int WINDOW     = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               quad_A,
  input  logic               quad_B,
  input  logic               quad_I,
  input  logic               enable,
  input  logic               clear,
  output logic signed [31:0] count,
  output logic signed [31:0] velocity,
  output logic               vel_valid,
  output logic               dir,
  output logic               error,
  output logic               index_seen
);

  localparam int         DATA_W   = 32;
  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);
  // Synchronisers plus filter need 2 + FILTER_LEN edges to show the real pin
  // levels; one more edge lets the reference pick them up without a step.
  localparam logic [4:0] PRIME_N  = 5'(FILTER_LEN + 3);

  // Signed step between two Gray-coded {A,B} states: +1, -1 or 0.
  function automatic logic signed [1:0] gray_step(input logic [1:0] prev,
                                                  input logic [1:0] cur);
    logic signed [1:0] s;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = 2'sb01;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: s = 2'sb11;
      default:                            s = 2'sb00;
    endcase
    return s;
  endfunction

  // Two's-complement add of a step; wraps modulo 2^32 by construction.
  function automatic logic signed [DATA_W-1:0] add_step(
      input logic signed [DATA_W-1:0] acc, input logic signed [1:0] s);
    return acc + $signed({{(DATA_W-2){s[1]}}, s});
  endfunction

  // ---- stage p0/p1: two-flop synchroniser, bit order {I, A, B}
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;

  // Bring the asynchronous encoder pins into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {quad_I, quad_A, quad_B};
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: per-channel run-length filter
  logic [2:0] filt_p2;
  logic [3:0] flt_cnt_p2 [3];

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_p2 <= '0;
      for (int k = 0; k < 3; k++) flt_cnt_p2[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync_p1[k] == filt_p2[k]) begin
          flt_cnt_p2[k] <= '0;
        end else if (flt_cnt_p2[k] == FLT_LAST) begin
          filt_p2[k]    <= sync_p1[k];
          flt_cnt_p2[k] <= '0;
        end else begin
          flt_cnt_p2[k] <= flt_cnt_p2[k] + 4'd1;
        end
      end
    end
  end

  // ---- stage p3: decode against the reference state, update outputs
  logic [2:0]        ref_p3;
  logic [4:0]        prime_cnt;
  logic              primed;
  logic signed [1:0] step_p2;
  logic              illegal_p2;
  logic              index_rise_p2;

  assign primed        = (prime_cnt == PRIME_N);
  assign step_p2       = (primed && enable) ? gray_step(ref_p3[1:0], filt_p2[1:0])
                                            : 2'sb00;
  assign illegal_p2    = primed && ((ref_p3[1:0] ^ filt_p2[1:0]) == 2'b11);
  assign index_rise_p2 = primed && filt_p2[2] && !ref_p3[2];

  // Reference always follows the filtered state; until primed it is adopted
  // silently so the first real levels after reset never count as a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_p3    <= '0;
      prime_cnt <= '0;
    end else begin
      ref_p3 <= filt_p2;
      if (!primed) prime_cnt <= prime_cnt + 5'd1;
    end
  end

  // Position and direction; clear beats a simultaneous step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      dir   <= 1'b1;
    end else begin
      if (clear) count <= '0;
      else       count <= add_step(count, step_p2);
      if (step_p2 != 2'sb00) dir <= ~step_p2[1];
    end
  end

  // Sticky flags; a set in the same cycle wins over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error      <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      if (illegal_p2)    error <= 1'b1;
      else if (clear)    error <= 1'b0;
      if (index_rise_p2) index_seen <= 1'b1;
      else if (clear)    index_seen <= 1'b0;
    end
  end

`ifdef QUADRATURE_DECODER_VELOCITY_EN
  localparam int                WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0]         win_cnt;
  logic signed [DATA_W-1:0] win_acc;

  // Free-running window; the terminal cycle's step lands in the published sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt   <= '0;
      win_acc   <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        win_cnt   <= '0;
        win_acc   <= '0;
        velocity  <= add_step(win_acc, step_p2);
        vel_valid <= 1'b1;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        win_acc <= add_step(win_acc, step_p2);
      end
    end
  end
`else
  logic unused_window;
  assign unused_window = (WINDOW > 1);
  assign velocity      = '0;
  assign vel_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: table-driven settled-state vectors, hand
// sequences for latency/glitch/clear-collision/reset corners, velocity window
// checks (or the tied-off behaviour), and a randomized run against a model.
module tb_quadrature_decoder;

  localparam int FL  = 3;
  localparam int WIN = 100;

  logic clk = 1'b0;
  logic reset, qa, qb, qi, en, clr;
  logic signed [31:0] count, velocity;
  logic vel_valid, dir, error, index_seen;

  int n_chk = 0;
  int n_err = 0;

  quadrature_decoder #(.FILTER_LEN(FL), .WINDOW(WIN)) dut (
    .clk(clk), .reset(reset), .quad_A(qa), .quad_B(qb), .quad_I(qi),
    .enable(en), .clear(clr), .count(count), .velocity(velocity),
    .vel_valid(vel_valid), .dir(dir), .error(error), .index_seen(index_seen)
  );

  always #5 clk = ~clk;

`ifndef QUADRATURE_DECODER_VELOCITY_EN
  logic seen_vv = 1'b0;
  always @(posedge clk) if (vel_valid !== 1'b0) seen_vv <= 1'b1;
`endif

  // ---------------- reference model ----------------
  logic signed [31:0] m_count, m_vel, m_acc;
  bit   m_dir, m_err, m_idx, m_vv;
  int   m_win;
  bit [2:0] m_filt, m_prev;   // {I, A, B}
  bit [2:0] m_hist[$];        // pin samples, oldest first

  function automatic int gray_pos(input bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_dir = 1'b1; m_err = 1'b0; m_idx = 1'b0;
    m_vel = 0; m_vv = 1'b0; m_acc = 0; m_win = 0;
    m_filt = '0; m_prev = '0;
    m_hist.delete();
    for (int j = 0; j < FL + 2; j++) m_hist.push_back(3'b000);
  endtask

  // Model state after the coming rising edge, from the inputs held now.
  task automatic model_edge();
    int  delta, d;
    bit  ill, rise;
    if (reset) begin
      model_reset();
      return;
    end
    delta = (gray_pos(m_filt[1:0]) - gray_pos(m_prev[1:0]) + 4) % 4;
    ill   = (delta == 2);
    d     = (delta == 1) ? 1 : (delta == 3) ? -1 : 0;
    if (!en) d = 0;
    rise  = m_filt[2] && !m_prev[2];
    m_count = clr ? 32'sd0 : m_count + d;
    if (d != 0) m_dir = (d > 0);
    if (ill) m_err = 1'b1; else if (clr) m_err = 1'b0;
    if (rise) m_idx = 1'b1; else if (clr) m_idx = 1'b0;
    if (m_win == WIN - 1) begin
      m_vel = m_acc + d; m_vv = 1'b1; m_acc = 0; m_win = 0;
    end else begin
      m_vv = 1'b0; m_acc = m_acc + d; m_win++;
    end
    m_prev = m_filt;
    m_hist.push_back({qi, qa, qb});
    void'(m_hist.pop_front());
    // A channel's filtered level follows once FL samples, seen through the
    // two-flop delay, all agree.
    for (int c = 0; c < 3; c++) begin
      bit v, same;
      v = m_hist[0][c];
      same = 1'b1;
      for (int j = 1; j < FL; j++) if (m_hist[j][c] != v) same = 1'b0;
      if (same) m_filt[c] = v;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input int step);
    string s;
    s = $sformatf("rnd%0d", step);
    check({s, ".count"}, count, m_count);
    check({s, ".dir"}, {31'd0, dir}, {31'd0, m_dir});
    check({s, ".error"}, {31'd0, error}, {31'd0, m_err});
    check({s, ".index_seen"}, {31'd0, index_seen}, {31'd0, m_idx});
`ifdef QUADRATURE_DECODER_VELOCITY_EN
    check({s, ".velocity"}, velocity, m_vel);
    check({s, ".vel_valid"}, {31'd0, vel_valid}, {31'd0, m_vv});
`else
    check({s, ".velocity"}, velocity, 32'd0);
    check({s, ".vel_valid"}, {31'd0, vel_valid}, 32'd0);
`endif
  endtask

  typedef struct {
    bit a, b, i, en, clr;
    int hold;
    logic [31:0] cnt;
    bit dir, err, idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit a, b, i, e, c, input logic [31:0] cnt,
                     input bit d, er, ix);
    vec_t v;
    v.a = a; v.b = b; v.i = i; v.en = e; v.clr = c; v.hold = 10;
    v.cnt = cnt; v.dir = d; v.err = er; v.idx = ix;
    tbl.push_back(v);
  endtask

  initial begin
    //  a  b  i  en clr  count         dir err idx
    add(0, 1, 0, 1, 0, 32'd1,          1, 0, 0);
    add(1, 1, 0, 1, 0, 32'd2,          1, 0, 0);
    add(1, 0, 0, 1, 0, 32'd3,          1, 0, 0);
    add(0, 0, 0, 1, 0, 32'd4,          1, 0, 0);
    add(0, 1, 0, 1, 0, 32'd5,          1, 0, 0);
    add(1, 1, 0, 1, 0, 32'd6,          1, 0, 0);
    add(1, 0, 0, 1, 0, 32'd7,          1, 0, 0);
    add(0, 0, 0, 1, 0, 32'd8,          1, 0, 0);
    add(0, 1, 0, 0, 0, 32'd8,          1, 0, 0);
    add(1, 1, 0, 0, 0, 32'd8,          1, 0, 0);
    add(1, 0, 0, 0, 0, 32'd8,          1, 0, 0);
    add(0, 0, 0, 0, 0, 32'd8,          1, 0, 0);
    add(0, 0, 0, 1, 0, 32'd8,          1, 0, 0);
    add(1, 0, 0, 1, 0, 32'd7,          0, 0, 0);
    add(1, 1, 0, 1, 0, 32'd6,          0, 0, 0);
    add(1, 1, 1, 1, 0, 32'd6,          0, 0, 1);
    add(1, 1, 0, 1, 0, 32'd6,          0, 0, 1);
    add(1, 1, 0, 1, 1, 32'd0,          0, 0, 0);
    add(1, 1, 0, 1, 0, 32'd0,          0, 0, 0);
    add(0, 0, 0, 1, 0, 32'd0,          0, 1, 0);
    add(0, 1, 0, 1, 0, 32'd1,          1, 1, 0);
    add(0, 1, 0, 1, 1, 32'd0,          1, 0, 0);
    add(0, 0, 0, 1, 0, 32'hFFFF_FFFF,  0, 0, 0);
    add(1, 0, 0, 1, 0, 32'hFFFF_FFFE,  0, 0, 0);

    qa = 0; qb = 0; qi = 0; en = 1; clr = 0; reset = 1;
    model_reset();
    tick();
    do_reset();

    // Reset state
    check("rst.count", count, 32'd0);
    check("rst.dir", {31'd0, dir}, 32'd1);
    check("rst.error", {31'd0, error}, 32'd0);
    check("rst.index_seen", {31'd0, index_seen}, 32'd0);
    check("rst.velocity", velocity, 32'd0);
    check("rst.vel_valid", {31'd0, vel_valid}, 32'd0);
    tickn(10);

    // Table of settled states
    for (int k = 0; k < tbl.size(); k++) begin
      qa = tbl[k].a; qb = tbl[k].b; qi = tbl[k].i; en = tbl[k].en; clr = tbl[k].clr;
      tickn(tbl[k].hold);
      check($sformatf("vec%0d.count", k), count, tbl[k].cnt);
      check($sformatf("vec%0d.dir", k), {31'd0, dir}, {31'd0, tbl[k].dir});
      check($sformatf("vec%0d.error", k), {31'd0, error}, {31'd0, tbl[k].err});
      check($sformatf("vec%0d.index_seen", k), {31'd0, index_seen}, {31'd0, tbl[k].idx});
    end
    clr = 0; en = 1;

    // Latency: 10 -> 00 is a forward step, visible exactly 6 clocks later
    qa = 0;
    tickn(5);
    check("lat.before", count, 32'hFFFF_FFFE);
    tick();
    check("lat.after", count, 32'hFFFF_FFFF);
    tickn(10);

    // 2-clock glitch on A is rejected
    qa = 1; tickn(2); qa = 0; tickn(10);
    check("glitch.count", count, 32'hFFFF_FFFF);
    check("glitch.error", {31'd0, error}, 32'd0);

    // Clear in the same cycle as a step
    qb = 1; tickn(5); clr = 1; tick(); clr = 0;
    check("clrstep.count", count, 32'd0);
    check("clrstep.dir", {31'd0, dir}, 32'd1);
    tickn(3);
    check("clrstep.hold", count, 32'd0);

    // Clear in the same cycle as an illegal transition 01 -> 10
    qa = 1; qb = 0; tickn(5); clr = 1; tick(); clr = 0;
    check("clrill.error", {31'd0, error}, 32'd1);
    check("clrill.count", count, 32'd0);
    tickn(5);

    // Clear in the same cycle as an index edge
    qi = 1; tickn(5); clr = 1; tick(); clr = 0;
    check("clridx.index_seen", {31'd0, index_seen}, 32'd1);
    check("clridx.error", {31'd0, error}, 32'd0);
    tickn(5);

    // Backward step from a fresh reset wraps to all ones
    qa = 0; qb = 0; qi = 0;
    tickn(10);
    do_reset();
    tickn(10);
    qa = 1; tickn(10);
    check("wrap.count", count, 32'hFFFF_FFFF);
    check("wrap.dir", {31'd0, dir}, 32'd0);

    // Reset acts asynchronously, and levels of 11 at release are not a step
    qb = 1;
    reset = 1; #1;
    check("async.count", count, 32'd0);
    check("async.dir", {31'd0, dir}, 32'd1);
    tick(); tick(); reset = 0;
    tickn(20);
    check("adopt.count", count, 32'd0);
    check("adopt.error", {31'd0, error}, 32'd0);
    check("adopt.dir", {31'd0, dir}, 32'd1);

`ifdef QUADRATURE_DECODER_VELOCITY_EN
    // 5 forward, 2 backward inside the first window, then an empty window
    qa = 0; qb = 0;
    do_reset();
    tickn(8);
    {qa, qb} = 2'b01; tickn(6);
    {qa, qb} = 2'b11; tickn(6);
    {qa, qb} = 2'b10; tickn(6);
    {qa, qb} = 2'b00; tickn(6);
    {qa, qb} = 2'b01; tickn(6);
    {qa, qb} = 2'b00; tickn(6);
    {qa, qb} = 2'b10; tickn(6);
    tickn(49);
    check("vel.pre_valid", {31'd0, vel_valid}, 32'd0);
    tick();
    check("vel.valid", {31'd0, vel_valid}, 32'd1);
    check("vel.value", velocity, 32'd3);
    tick();
    check("vel.pulse_end", {31'd0, vel_valid}, 32'd0);
    check("vel.hold", velocity, 32'd3);
    tickn(99);
    check("vel2.valid", {31'd0, vel_valid}, 32'd1);
    check("vel2.value", velocity, 32'd0);
`endif

    // Randomized run against the model, with a reset mid-window
    qa = 0; qb = 0; qi = 0; en = 1; clr = 0;
    do_reset();
    tickn(10);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1537) begin
        qa = 0; qb = 0; qi = 0; en = 1; clr = 0;
        do_reset();
        tickn(10);
      end
      case ($urandom_range(0, 15))
        0: qa = ~qa;
        1: qb = ~qb;
        2: qi = ~qi;
        3: begin qa = ~qa; qb = ~qb; end
        default: ;
      endcase
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      tick();
      check_model(n);
    end

`ifndef QUADRATURE_DECODER_VELOCITY_EN
    check("novel.vel_valid_seen", {31'd0, seen_vv}, 32'd0);
    check("novel.velocity", velocity, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
